// File: rtl/sdram_uart_pkg.sv
// Shared constants for the UART <-> SDRAM byte buffer: burst/FIFO defaults and FSM encodings.
package sdram_uart_pkg;

  localparam int unsigned BurstLenDef  = 4;
  localparam int unsigned FifoDepthDef = 16;

  localparam logic W_IDLE = 1'b0;
  localparam logic W_BUSY = 1'b1;

  localparam logic R_IDLE = 1'b0;
  localparam logic R_BUSY = 1'b1;

  localparam logic T_IDLE = 1'b0;
  localparam logic T_HOLD = 1'b1;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO; head reads 0 while empty, overflowing pushes are dropped.
module sync_fifo_fwft #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_W     = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] head_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_W:0]       count_o
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FullCount = {1'b1, {ADDR_W{1'b0}}};

  logic [DATA_WIDTH-1:0] mem_q [Depth];
  logic [ADDR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]       count_q;
  logic                  push_ok, pop_ok;

  assign full_o  = (count_q == FullCount);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  // Full: pop wins and the push is dropped; empty: pop is ignored.
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/sdram_uart_buffer.sv
// UART RX -> write FIFO -> SDRAM write path, and SDRAM read path -> read FIFO -> UART TX.
module sdram_uart_buffer
  import sdram_uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = FifoDepthDef,
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned BURST_LEN  = BurstLenDef
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  input  logic                  rd_req,
  output logic                  wr_trig,
  output logic                  rd_trig,
  input  logic                  wfifo_rd_en,
  output logic [DATA_WIDTH-1:0] wfifo_rd_data,
  input  logic                  rfifo_wr_en,
  input  logic [DATA_WIDTH-1:0] rfifo_wr_data,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_start,
  input  logic                  tx_busy,
  output logic                  wfifo_ovf,
  output logic                  rfifo_ovf
);

  localparam int unsigned CntW = $clog2(BURST_LEN + 1);
  localparam logic [CntW-1:0]   LastBeat = CntW'(BURST_LEN - 1);
  localparam logic [ADDR_W:0]   BurstCnt = (ADDR_W + 1)'(BURST_LEN);
  localparam logic [ADDR_W:0]   DepthCnt = (ADDR_W + 1)'(FIFO_DEPTH);

  logic                  w_full, w_empty, r_full, r_empty;
  logic [ADDR_W:0]       w_count, r_count;
  logic [DATA_WIDTH-1:0] r_head;

  logic                  w_state_q, w_state_d, r_state_q, r_state_d, t_state_q, t_state_d;
  logic [CntW-1:0]       w_cnt_q, w_cnt_d, r_cnt_q, r_cnt_d;
  logic                  rd_pend_q, rd_pend_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  wovf_q, wovf_d, rovf_q, rovf_d;
  logic                  wr_elig, rd_fire, w_pop_ok, tx_pop;

  sync_fifo_fwft #(.DATA_WIDTH(DATA_WIDTH), .ADDR_W(ADDR_W)) u_wfifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (rx_valid),
    .data_i  (rx_data),
    .pop_i   (wfifo_rd_en),
    .head_o  (wfifo_rd_data),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (w_count)
  );

  sync_fifo_fwft #(.DATA_WIDTH(DATA_WIDTH), .ADDR_W(ADDR_W)) u_rfifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (rfifo_wr_en),
    .data_i  (rfifo_wr_data),
    .pop_i   (tx_pop),
    .head_o  (r_head),
    .full_o  (r_full),
    .empty_o (r_empty),
    .count_o (r_count)
  );

  assign w_pop_ok = wfifo_rd_en & ~w_empty;
  // Write has priority; a trigger only fires with both FSMs idle, so the two are exclusive.
  assign wr_elig  = (w_state_q == W_IDLE) && (r_state_q == R_IDLE) && (w_count >= BurstCnt);
  assign rd_fire  = rd_pend_q && (r_state_q == R_IDLE) && (w_state_q == W_IDLE) && !wr_elig &&
                    ((DepthCnt - r_count) >= BurstCnt);
  assign wr_trig  = wr_elig;
  assign rd_trig  = rd_fire;
  assign tx_pop   = (t_state_q == T_IDLE) && !r_empty && !tx_busy;

  assign tx_data   = tx_data_q;
  assign tx_start  = (t_state_q == T_HOLD);
  assign wfifo_ovf = wovf_q;
  assign rfifo_ovf = rovf_q;

  always_comb begin
    w_state_d = w_state_q;
    w_cnt_d   = w_cnt_q;
    if (w_state_q == W_IDLE) begin
      if (wr_elig) begin
        w_state_d = W_BUSY;
        w_cnt_d   = '0;
      end
    end else if (w_pop_ok) begin
      if (w_cnt_q == LastBeat) begin
        w_state_d = W_IDLE;
        w_cnt_d   = '0;
      end else begin
        w_cnt_d = w_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    r_state_d = r_state_q;
    r_cnt_d   = r_cnt_q;
    if (r_state_q == R_IDLE) begin
      if (rd_fire) begin
        r_state_d = R_BUSY;
        r_cnt_d   = '0;
      end
    end else if (rfifo_wr_en) begin
      if (r_cnt_q == LastBeat) begin
        r_state_d = R_IDLE;
        r_cnt_d   = '0;
      end else begin
        r_cnt_d = r_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    // A request landing on the clearing cycle re-arms rather than merges.
    rd_pend_d = rd_fire ? rd_req : (rd_pend_q | rd_req);
    t_state_d = tx_pop ? T_HOLD : T_IDLE;
    tx_data_d = tx_pop ? r_head : tx_data_q;
    wovf_d    = wovf_q | (rx_valid & w_full);
    rovf_d    = rovf_q | (rfifo_wr_en & r_full);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      t_state_q <= T_IDLE;
      w_cnt_q   <= '0;
      r_cnt_q   <= '0;
      rd_pend_q <= 1'b0;
      tx_data_q <= '0;
      wovf_q    <= 1'b0;
      rovf_q    <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      t_state_q <= t_state_d;
      w_cnt_q   <= w_cnt_d;
      r_cnt_q   <= r_cnt_d;
      rd_pend_q <= rd_pend_d;
      tx_data_q <= tx_data_d;
      wovf_q    <= wovf_d;
      rovf_q    <= rovf_d;
    end
  end

endmodule

// File: tb/tb_sdram_uart_buffer.sv
// Scoreboard bench: queue models of both FIFOs, SDRAM write/read models and a busy-holding UART TX.
module tb_sdram_uart_buffer;

  logic       clk = 1'b0;
  logic       rst_n, rx_valid, rd_req, rfifo_wr_en, tx_busy, wr_pop, man_pop;
  logic [7:0] rx_data, rfifo_wr_data;
  logic       wfifo_rd_en;
  logic       wr_trig, rd_trig, tx_start, wfifo_ovf, rfifo_ovf;
  logic [7:0] wfifo_rd_data, tx_data;

  assign wfifo_rd_en = wr_pop | man_pop;

  sdram_uart_buffer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rd_req        (rd_req),
    .wr_trig       (wr_trig),
    .rd_trig       (rd_trig),
    .wfifo_rd_en   (wfifo_rd_en),
    .wfifo_rd_data (wfifo_rd_data),
    .rfifo_wr_en   (rfifo_wr_en),
    .rfifo_wr_data (rfifo_wr_data),
    .tx_data       (tx_data),
    .tx_start      (tx_start),
    .tx_busy       (tx_busy),
    .wfifo_ovf     (wfifo_ovf),
    .rfifo_ovf     (rfifo_ovf)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int cyc = 0, last_pop_cyc = 0, rd_gap = 0;
  int wr_n = 0, rd_n = 0, tx_n = 0, rd_bursts = 0;
  int wr_left = 0, rd_left = 0;
  int wr_pops_n = 4;
  bit wr_auto = 1'b1;
  bit exp_wovf = 1'b0;
  logic [7:0] wq[$];
  logic [7:0] txq[$];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic req);
    rx_data  = b;
    rx_valid = 1'b1;
    rd_req   = req;
    step();
    rx_valid = 1'b0;
    rd_req   = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_wr_trig"}, int'(wr_trig), 0);
    chk({tag, "_rd_trig"}, int'(rd_trig), 0);
    chk({tag, "_tx_start"}, int'(tx_start), 0);
    chk({tag, "_tx_data"}, int'(tx_data), 0);
    chk({tag, "_wfifo_rd_data"}, int'(wfifo_rd_data), 0);
    chk({tag, "_wfifo_ovf"}, int'(wfifo_ovf), 0);
    chk({tag, "_rfifo_ovf"}, int'(rfifo_ovf), 0);
  endtask

  task automatic wait_rd(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (!rd_trig && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("rd_trig_wait", int'(rd_trig), 1);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((txq.size() != 0 || tx_busy) && n < budget) begin
      step();
      n++;
    end
    chk("tx_drain_left", int'(txq.size()), 0);
  endtask

  // Scoreboard / monitor: model state updated at the negedge, DUT compared before update.
  initial begin : monitor
    int  exp_head;
    bit  w_full;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        wq.delete();
        txq.delete();
        exp_wovf = 1'b0;
        wr_left  = 0;
        rd_left  = 0;
      end else begin
        exp_head = (wq.size() > 0) ? int'(wq[0]) : 0;
        chk("wfifo_head", int'(wfifo_rd_data), exp_head);
        chk("wfifo_ovf", int'(wfifo_ovf), int'(exp_wovf));
        chk("rfifo_ovf", int'(rfifo_ovf), 0);
        chk("trig_exclusive", int'(wr_trig & rd_trig), 0);
        if (wr_trig) chk("wr_while_rd_busy", rd_left, 0);
        if (rd_trig) chk("rd_while_wr_busy", wr_left, 0);
        if (tx_start) begin
          chk("tx_while_busy", int'(tx_busy), 0);
          if (txq.size() == 0) chk("tx_unexpected", int'(tx_start), 0);
          else chk("tx_data", int'(tx_data), int'(txq.pop_front()));
          tx_n++;
        end
        w_full = (wq.size() == 16);
        if (wfifo_rd_en && wq.size() > 0) begin
          void'(wq.pop_front());
          last_pop_cyc = cyc;
          if (wr_left > 0) wr_left--;
        end
        if (rx_valid) begin
          if (!w_full) wq.push_back(rx_data);
          else exp_wovf = 1'b1;
        end
        if (rfifo_wr_en && rd_left > 0) rd_left--;
        if (wr_trig) begin
          wr_n++;
          wr_left = 4;
        end
        if (rd_trig) begin
          rd_n++;
          rd_left = 4;
          rd_gap  = cyc - last_pop_cyc;
        end
      end
    end
  end

  // SDRAM write path: pops a burst starting the cycle after wr_trig.
  initial begin : sdram_wr_model
    wr_pop = 1'b0;
    forever begin
      @(negedge clk);
      if (wr_trig && wr_auto && rst_n) begin
        for (int i = 0; i < wr_pops_n; i++) begin
          step();
          wr_pop = 1'b1;
        end
        step();
        wr_pop = 1'b0;
      end
    end
  end

  // SDRAM read path: returns a burst starting the cycle after rd_trig.
  initial begin : sdram_rd_model
    rfifo_wr_en   = 1'b0;
    rfifo_wr_data = 8'h00;
    forever begin
      @(negedge clk);
      if (rd_trig && rst_n) begin
        for (int i = 0; i < 4; i++) begin
          step();
          rfifo_wr_en   = 1'b1;
          rfifo_wr_data = (rd_bursts == 0) ? 8'(8'hA0 + i) : 8'($urandom);
          txq.push_back(rfifo_wr_data);
        end
        step();
        rfifo_wr_en = 1'b0;
        rd_bursts++;
      end
    end
  end

  // UART TX: busy from the cycle after tx_start for 10 cycles.
  initial begin : uart_tx_model
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start && rst_n) begin
        step();
        tx_busy = 1'b1;
        repeat (10) step();
        tx_busy = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int         snap_w, snap_r, snap_t;
    logic [7:0] b [17];
    logic [7:0] one;
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; rd_req = 1'b0; man_pop = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk_zero_outputs("reset");
    step();

    // Basic burst: head latency, trigger latency, in-order pops, single trigger.
    send_byte(8'h11, 1'b0);
    @(negedge clk);
    chk("rx_to_head", int'(wfifo_rd_data), 8'h11);
    step();
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    @(negedge clk);
    chk("wr_trig_latency", int'(wr_trig), 1);
    step();
    repeat (12) step();
    chk("single_wr_trig", wr_n, 1);

    // Three bytes do not trigger; the 4th does; the 5th stays buffered.
    snap_w = wr_n;
    repeat (3) send_byte(8'($urandom), 1'b0);
    repeat (6) step();
    chk("no_trig_3_bytes", wr_n - snap_w, 0);
    repeat (2) send_byte(8'($urandom), 1'b0);
    repeat (10) step();
    chk("trig_on_4th", wr_n - snap_w, 1);
    repeat (3) send_byte(8'($urandom), 1'b0);
    @(negedge clk);
    chk("trig_with_leftover", int'(wr_trig), 1);
    step();
    repeat (10) step();

    // rd_req with the 4th byte: write first, read after the 4 pops; second pulse merges.
    snap_w = wr_n; snap_r = rd_n; snap_t = tx_n;
    repeat (3) send_byte(8'($urandom), 1'b0);
    send_byte(8'($urandom), 1'b1);
    rd_req = 1'b1;
    @(negedge clk);
    chk("prio_wr_trig", int'(wr_trig), 1);
    chk("prio_rd_blocked", int'(rd_trig), 0);
    step();
    rd_req = 1'b0;
    wait_rd(60);
    @(negedge clk);
    chk("rd_after_last_pop", rd_gap, 1);
    @(negedge clk);
    @(negedge clk);
    chk("rfifo_to_tx_start", int'(tx_start), 1);
    chk("first_tx_byte", int'(tx_data), 8'hA0);
    step();
    drain(600);
    chk("tx_count", tx_n - snap_t, 4);
    chk("rd_merged", rd_n - snap_r, 1);
    chk("wr_once", wr_n - snap_w, 1);

    // Overflow with no pops; then push+pop on a full FIFO.
    wr_auto = 1'b0;
    for (int i = 0; i < 17; i++) begin
      b[i] = 8'($urandom);
      send_byte(b[i], 1'b0);
    end
    @(negedge clk);
    chk("ovf_set", int'(wfifo_ovf), 1);
    chk("ovf_head_first", int'(wfifo_rd_data), int'(b[0]));
    step();
    rx_data = 8'($urandom); rx_valid = 1'b1; man_pop = 1'b1;
    step();
    rx_valid = 1'b0; man_pop = 1'b0;
    @(negedge clk);
    chk("full_push_pop_head", int'(wfifo_rd_data), int'(b[1]));
    step();
    repeat (20) step();
    @(negedge clk);
    chk("ovf_sticky", int'(wfifo_ovf), 1);
    step();
    do_reset();
    @(negedge clk);
    chk_zero_outputs("ovf_reset");
    step();
    wr_auto = 1'b1;

    // Reset in the middle of a burst after 2 pops.
    wr_pops_n = 2;
    repeat (4) send_byte(8'($urandom), 1'b0);
    repeat (4) step();
    do_reset();
    @(negedge clk);
    chk_zero_outputs("midburst_reset");
    step();
    wr_pops_n = 4;
    one = 8'($urandom);
    rx_data = one; rx_valid = 1'b1; man_pop = 1'b1;
    step();
    rx_valid = 1'b0; man_pop = 1'b0;
    @(negedge clk);
    chk("empty_push_pop_head", int'(wfifo_rd_data), int'(one));
    step();
    repeat (3) send_byte(8'($urandom), 1'b0);
    @(negedge clk);
    chk("trig_after_reset", int'(wr_trig), 1);
    step();
    repeat (10) step();

    // Randomised traffic against the scoreboard.
    snap_r = rd_n; snap_t = tx_n;
    for (int it = 0; it < 40; it++) begin
      int n;
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) send_byte(8'($urandom), 1'($urandom_range(0, 7) == 0));
      repeat ($urandom_range(0, 3)) step();
    end
    repeat (3) begin
      repeat (50) step();
      drain(3000);
    end
    chk("rd_tx_balance", tx_n - snap_t, (rd_n - snap_r) * 4);
    chk("wfifo_residue_below_burst", int'(wq.size() < 4), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
